// File: rtl/game_pkg.sv
// Shared game-level types: state encoding, obstacle count and counter widths.
// Used by game_ctrl, pixel_gen and the score display.
package game_pkg;

  localparam int N_OBS   = 4;
  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } game_state_t;

  function automatic logic [2:0] popcount4(input logic [N_OBS-1:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// 4-way round-robin pick: first request at or after ptr, wrapping 3->0.
// Latency: combinational; backpressure: none, requests are levels held by the requester.
module rr_arb4
  import game_pkg::*;
(
  input  logic [N_OBS-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_OBS-1:0] gnt,
  output logic [1:0]       idx,
  output logic             vld
);

  logic [1:0] cand;

  always_comb begin
    idx  = ptr;
    vld  = 1'b0;
    cand = ptr;
    for (int i = 0; i < N_OBS; i++) begin
      cand = ptr + 2'(i);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
    gnt = vld ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: play/pause/over FSM, lives, score, one obstacle respawn grant per frame.
// Latency: all outputs registered, one cycle after the causing input; backpressure: none.
module game_ctrl
  import game_pkg::*;
#(
  parameter int         LIVES      = 3,
  parameter int         HIT_FRAMES = 60,
  parameter int         Y_MIN      = 30,
  parameter int         Y_MAX      = 440,
  parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic [N_OBS-1:0]   obs_pass,
  input  logic [N_OBS-1:0]   respawn_req,
  output logic               run,
  output logic               clear,
  output logic [N_OBS-1:0]   spawn_gnt,
  output logic [9:0]         spawn_y,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  localparam int                 Y_RANGE    = Y_MAX - Y_MIN + 1;
  localparam logic [9:0]         RANGE_W    = 10'(Y_RANGE);
  localparam logic [9:0]         Y_MIN_W    = 10'(Y_MIN);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [7:0]         HIT_INIT   = 8'(HIT_FRAMES);

  // A single conditional subtract only covers the 9-bit LFSR slice when 2*range > 512.
  if (2 * Y_RANGE <= 512 || Y_MAX <= Y_MIN || Y_RANGE > 512) begin : g_bad_yrange
    $error("game_ctrl: Y_MIN/Y_MAX give an unsupported spawn range");
  end
  if (LIVES < 1 || LIVES > 3 || HIT_FRAMES < 1 || HIT_FRAMES > 255) begin : g_bad_counts
    $error("game_ctrl: LIVES or HIT_FRAMES out of range");
  end

  game_state_t      st;
  logic             start_q;
  logic [1:0]       rr_ptr;
  logic [9:0]       lfsr;
  logic [7:0]       pause_cnt;

  logic             start_rise;
  logic [N_OBS-1:0] arb_gnt;
  logic [1:0]       arb_idx;
  logic             arb_vld;
  logic [9:0]       lane_raw;
  logic [9:0]       lane_off;
  logic [9:0]       lane_y;
  logic [8:0]       score_sum;
  logic [7:0]       score_sat;

  assign start_rise = start & ~start_q;
  assign state      = st;

  rr_arb4 u_arb (
    .req (respawn_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign lane_raw  = {1'b0, lfsr[8:0]};
  assign lane_off  = (lane_raw >= RANGE_W) ? (lane_raw - RANGE_W) : lane_raw;
  assign lane_y    = Y_MIN_W + lane_off;

  assign score_sum = {1'b0, score} + {6'b0, popcount4(obs_pass)};
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      run       <= 1'b0;
      clear     <= 1'b0;
      spawn_gnt <= '0;
      spawn_y   <= Y_MIN_W;
      lives     <= LIVES_INIT;
      score     <= '0;
      rr_ptr    <= 2'd0;
      lfsr      <= LFSR_SEED;
      pause_cnt <= 8'd0;
      start_q   <= 1'b0;
    end else begin
      start_q   <= start;
      lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      clear     <= 1'b0;
      spawn_gnt <= '0;

      if (st == S_PLAY && frame_tick && arb_vld) begin
        spawn_gnt <= arb_gnt;
        spawn_y   <= lane_y;
        rr_ptr    <= arb_idx + 2'd1;
      end

      case (st)
        S_IDLE: begin
          if (start_rise) begin
            st     <= S_PLAY;
            run    <= 1'b1;
            clear  <= 1'b1;
            score  <= '0;
            lives  <= LIVES_INIT;
            rr_ptr <= 2'd0;
          end
        end
        S_PLAY: begin
          // A hit swallows any same-cycle obstacle passes.
          if (hit) begin
            run <= 1'b0;
            if (lives > 2'd1) begin
              st        <= S_PAUSE;
              lives     <= lives - 2'd1;
              pause_cnt <= HIT_INIT;
            end else begin
              st    <= S_OVER;
              lives <= '0;
            end
          end else begin
            score <= score_sat;
          end
        end
        S_PAUSE: begin
          if (frame_tick) begin
            if (pause_cnt == 8'd1) begin
              st        <= S_PLAY;
              run       <= 1'b1;
              clear     <= 1'b1;
              rr_ptr    <= 2'd0;
              pause_cnt <= 8'd0;
            end else begin
              pause_cnt <= pause_cnt - 8'd1;
            end
          end
        end
        S_OVER: begin
          if (start_rise) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed and random stimulus against a behavioural model of the game rules.
module tb_game_ctrl;

  localparam int L_LIVES = 3;
  localparam int L_HIT   = 60;
  localparam int L_YMIN  = 30;
  localparam int L_YMAX  = 440;
  localparam int L_SEED  = 'h2A5;

  logic       clk;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic       hit;
  logic [3:0] obs_pass;
  logic [3:0] respawn_req;
  logic       run;
  logic       clear;
  logic [3:0] spawn_gnt;
  logic [9:0] spawn_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 play, 2 pause, 3 over.
  int m_mode, m_lives, m_score, m_ptr, m_lfsr, m_pause, m_start_q;
  int e_clear, e_gnt, e_y;

  game_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_tick  (frame_tick),
    .hit         (hit),
    .obs_pass    (obs_pass),
    .respawn_req (respawn_req),
    .run         (run),
    .clear       (clear),
    .spawn_gnt   (spawn_gnt),
    .spawn_y     (spawn_y),
    .lives       (lives),
    .score       (score),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lives = L_LIVES; m_score = 0; m_ptr = 0;
    m_lfsr = L_SEED; m_pause = 0; m_start_q = 0;
    e_clear = 0; e_gnt = 0; e_y = L_YMIN;
  endtask

  task automatic model_step();
    int rise;
    int g;
    rise = (start && !m_start_q) ? 1 : 0;
    m_start_q = start ? 1 : 0;
    e_clear = 0;
    e_gnt = 0;
    if (m_mode == 1 && frame_tick && respawn_req != 4'b0) begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && respawn_req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      e_gnt = 1 << g;
      m_ptr = (g + 1) % 4;
      e_y = L_YMIN + (m_lfsr % 512) % (L_YMAX - L_YMIN + 1);
    end
    case (m_mode)
      0: if (rise) begin
        m_mode = 1; e_clear = 1; m_score = 0; m_lives = L_LIVES; m_ptr = 0;
      end
      1: if (hit) begin
        if (m_lives > 1) begin m_lives--; m_pause = L_HIT; m_mode = 2; end
        else begin m_lives = 0; m_mode = 3; end
      end else begin
        m_score = m_score + $countones(obs_pass);
        if (m_score > 255) m_score = 255;
      end
      2: if (frame_tick) begin
        if (m_pause == 1) begin m_mode = 1; e_clear = 1; m_ptr = 0; m_pause = 0; end
        else m_pause--;
      end
      default: if (rise) m_mode = 0;
    endcase
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 'h3FF;
  endtask

  task automatic check_outputs();
    check("state", state, m_mode);
    check("run", run, (m_mode == 1) ? 1 : 0);
    check("clear", clear, e_clear);
    check("spawn_gnt", spawn_gnt, e_gnt);
    check("spawn_y", spawn_y, e_y);
    check("lives", lives, m_lives);
    check("score", score, m_score);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_lives", lives, L_LIVES);
    check("rst_gnt", spawn_gnt, 0);
    check("rst_run", run, 0);
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  initial begin
    int nclr;
    int rr_exp[3];
    rr_exp = '{2, 8, 2};
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    obs_pass = 4'b0; respawn_req = 4'b0;
    #2;
    async_reset();

    // Start held for five cycles gives a single clear.
    start = 1'b1;
    cycle();
    check("start_state", state, 1);
    check("start_run", run, 1);
    nclr = clear;
    repeat (4) begin cycle(); nclr += clear; end
    check("start_clears", nclr, 1);
    start = 1'b0;
    cycle();

    obs_pass = 4'b1011; cycle(); check("score_a", score, 3);
    obs_pass = 4'b0001; cycle(); check("score_b", score, 4);
    obs_pass = 4'b1111; repeat (62) cycle(); check("score_252", score, 252);
    obs_pass = 4'b0011; cycle(); check("score_254", score, 254);
    obs_pass = 4'b1111; cycle(); check("score_sat", score, 255);
    cycle(); check("score_hold", score, 255);
    obs_pass = 4'b0;

    hit = 1'b1; cycle();
    check("hit_state", state, 2); check("hit_lives", lives, 2); check("hit_run", run, 0);
    frames(30);
    hit = 1'b0;
    frames(29);
    check("pause_59", state, 2);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    check("pause_exit", state, 1); check("pause_clear", clear, 1);
    cycle();

    respawn_req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
      check("rr_gnt", spawn_gnt, rr_exp[k]);
      check("rr_y_range", (spawn_y >= L_YMIN && spawn_y <= L_YMAX) ? 1 : 0, 1);
      cycle();
      check("rr_idle", spawn_gnt, 0);
    end
    respawn_req = 4'b0;

    hit = 1'b1; cycle(); hit = 1'b0;
    frames(L_HIT);
    check("second_play", state, 1);
    hit = 1'b1; cycle(); hit = 1'b0;
    check("over_state", state, 3); check("over_lives", lives, 0); check("over_run", run, 0);
    start = 1'b1; cycle(); check("over_idle", state, 0); check("over_noclr", clear, 0);
    start = 1'b0; cycle(); check("idle_hold", state, 0);
    start = 1'b1; cycle();
    check("replay", state, 1); check("replay_clr", clear, 1); check("replay_lives", lives, 3);
    start = 1'b0; cycle();

    obs_pass = 4'b0001; cycle(); check("g3_score", score, 1);
    hit = 1'b1; cycle(); hit = 1'b0; obs_pass = 4'b0;
    check("hitpass_score", score, 1); check("hitpass_lives", lives, 2);
    frames(5);
    #2;
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 15) == 0);
      frame_tick  = ($urandom_range(0, 7) == 0);
      hit         = ($urandom_range(0, 40) == 0);
      obs_pass    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      respawn_req = 4'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2;
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game-level sequencer for the obstacle-dodge pixel pipeline. It owns the play/pause/game-over state, lives and score, and schedules obstacle respawns: one round-robin grant per frame, with a pseudo-random lane Y from an LFSR. It sits between the button debouncers and the pixel/object generator, gating object motion and issuing position-clear pulses.

Parameters:
LIVES, 3, lives loaded at game start (1..3)
HIT_FRAMES, 60, frames frozen after a non-fatal hit (1..255)
Y_MIN, 30, lowest legal spawn Y
Y_MAX, 440, highest legal spawn Y (Y_MAX > Y_MIN, Y_MAX-Y_MIN < 512)
LFSR_SEED, 10'h2A5, non-zero LFSR reset value

Ports:
clk  in  1  pixel-domain clock
reset  in  1  async active-high reset
start  in  1  debounced start button, level
frame_tick  in  1  one-cycle pulse per frame (y==481, x==0)
hit  in  1  collision flag from generator, level, sampled only in PLAY
obs_pass  in  4  per-obstacle one-cycle pulse: obstacle passed player
respawn_req  in  4  per-obstacle level: obstacle reached left edge, awaiting respawn
run  out  1  high in PLAY; enables object motion
clear  out  1  one-cycle pulse; generator reloads start positions
spawn_gnt  out  4  one-hot one-cycle grant, coincident with spawn_y
spawn_y  out  10  lane Y for the granted obstacle
lives  out  2  remaining lives
score  out  8  obstacles passed, saturating
state  out  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3

Behaviour:
Interface: reset reset, asynchronous, active-high; clock clk.
- Reset: state=IDLE, run=0, clear=0, spawn_gnt=0, spawn_y=Y_MIN, lives=LIVES, score=0, rr_ptr=0, lfsr=LFSR_SEED, pause_cnt=0, start_q=0.
- start_rise = start & ~start_q, with start_q registered every cycle.
- IDLE: on start_rise -> PLAY next cycle. On the same edge: clear=1, score=0, lives=LIVES.
- PLAY: run=1.
  - hit=1 with lives>1 -> PAUSE; lives-1; pause_cnt=HIT_FRAMES.
  - hit=1 with lives==1 -> OVER; lives=0.
  - hit has priority over obs_pass in the same cycle: no score change that cycle.
- PAUSE: run=0. pause_cnt decrements on frame_tick.
  - On the frame_tick where pause_cnt==1 -> PLAY, with clear=1 on that transition edge.
  - hit is ignored in PAUSE.
- OVER: run=0; score and lives hold. start_rise -> IDLE (no clear). A second start_rise is needed to play.
- start_rise in PLAY or PAUSE is ignored.
- Score: in PLAY without hit, score += popcount(obs_pass), saturating at 255, same-cycle registered.
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1, shifts every cycle regardless of state. It never reaches 0.
- Spawn scheduler (PLAY only):
  - On frame_tick, if respawn_req != 0, grant the first set bit at or after rr_ptr, wrapping 3->0.
  - spawn_gnt is that one-hot value for exactly one cycle (the cycle after frame_tick).
  - rr_ptr = granted index + 1 mod 4. At most one grant per frame.
  - spawn_y = Y_MIN + (lfsr[8:0] mod (Y_MAX-Y_MIN+1)), registered with the grant.
  - mod is realised as a single conditional subtract (value ≥ range -> value - range). This is valid because 512 < 2*range for defaults; the parameter check asserts 2*(Y_MAX-Y_MIN+1) > 512.
  - Outside PLAY: spawn_gnt=0 and rr_ptr holds.
- clear also resets rr_ptr to 0.
- Async reset mid-game returns everything to reset values immediately. No clear pulse is emitted on reset.

Decomposition:
- Package game_pkg: state encoding (IDLE/PLAY/PAUSE/OVER), N_OBS=4, score width 8, lives width 2. Shared with pixel_gen and the score display.
- One sub-module: rr_arb4 (combinational 4-way round-robin pick given req and ptr; returns one-hot grant and index). The LFSR and counters stay inline.

Test Plan:
- Reset, then start held high for 5 cycles -> exactly one clear pulse; state=1 next cycle; lives=3, score=0; run=1.
- In PLAY, obs_pass=4'b1011 for one cycle, then 4'b0001 -> score=3, then 4. With score=254 and obs_pass=4'b1111 -> score=255, and it holds there.
- Hit in PLAY with lives=3 -> state=2, lives=2, run=0. 59 frame_ticks: still PAUSE. 60th frame_tick -> state=1 with clear pulse.
- Hit with lives=1 -> state=3, lives=0, run=0. start_rise -> IDLE with no clear; second start_rise -> PLAY with clear, lives=3.
- respawn_req=4'b1010, rr_ptr=0 across 3 frame_ticks -> grants 0010, 1000, 0010. Each spawn_y lies in [30,440]. No grant on cycles without frame_tick.
- Simultaneous hit and obs_pass=4'b0001 in PLAY -> score unchanged; lives decremented. Async reset asserted during PAUSE -> state=0, lives=3, spawn_gnt=0 without waiting for a clock edge.
